// File: rtl/countdown_timer_16bit.sv
// countdown_timer_16bit: loadable 16-bit countdown timer with prescaler, hold and auto-reload
module decrement_16bit (
  input  logic [15:0] a,
  output logic [15:0] deca,
  output logic        ovf
);
  assign {ovf, deca} = {1'b0, a} - 17'd1;
endmodule

module countdown_timer_16bit #(
  parameter int PRESCALE = 1,
  parameter int PS_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start,
  input  logic        stop,
  input  logic        auto_reload,
  output logic [15:0] count,
  output logic        busy,
  output logic        running,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [15:0] rld, count_n, rld_n, deca;
  logic [PS_WIDTH-1:0] ps, ps_n;
  logic done_n, ovf, tick;
  decrement_16bit u_dec (.a(count), .deca(deca), .ovf(ovf));
  assign tick = (state == RUN) && (ps == PS_WIDTH'(PRESCALE - 1));
  assign busy = (state == RUN) || (state == HOLD);
  assign running = state == RUN;
  always_comb begin
    state_n = state;
    count_n = count;
    rld_n = rld;
    ps_n = ps;
    done_n = 1'b0;
    if (load) begin
      count_n = load_val;
      rld_n = load_val;
      ps_n = '0;
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          ps_n = '0;
          state_n = (count != 16'd0) ? RUN : DONE;
          done_n = count == 16'd0;
        end
        RUN: if (stop) begin
          state_n = HOLD;
        end else if (tick) begin
          ps_n = '0;
          if (count > 16'd1) begin
            // ovf only asserts at zero, so this never wraps
            count_n = ovf ? count : deca;
          end else if (count == 16'd1 && auto_reload && rld != 16'd0) begin
            count_n = rld;
            done_n = 1'b1;
          end else begin
            count_n = '0;
            done_n = 1'b1;
            state_n = DONE;
          end
        end else begin
          ps_n = ps + 1'b1;
        end
        HOLD: if (start && !stop) state_n = RUN;
        DONE: if (start) begin
          count_n = rld;
          ps_n = '0;
          state_n = (rld != 16'd0) ? RUN : DONE;
          done_n = rld == 16'd0;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      rld <= '0;
      ps <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      rld <= rld_n;
      ps <= ps_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_countdown_timer_16bit.sv
// tb_countdown_timer_16bit: directed checks on PRESCALE=1 and PRESCALE=4 instances sharing stimulus
module tb_countdown_timer_16bit;
  logic clk = 0, rst = 1, load = 0, start = 0, stop = 0, auto_reload = 0;
  logic [15:0] load_val = '0;
  logic [15:0] count1, count4;
  logic busy1, running1, done1, busy4, running4, done4;
  int checks = 0, errors = 0;

  countdown_timer_16bit #(.PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .auto_reload(auto_reload), .count(count1), .busy(busy1),
    .running(running1), .done(done1));
  countdown_timer_16bit #(.PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .auto_reload(auto_reload), .count(count4), .busy(busy4),
    .running(running4), .done(done4));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic [15:0] c, input logic b, input logic r, input logic d);
    checks++;
    if (count1 !== c || busy1 !== b || running1 !== r || done1 !== d) begin
      errors++;
      $display("FAIL %s: got count=%h busy=%b running=%b done=%b, expected count=%h busy=%b running=%b done=%b",
               name, count1, busy1, running1, done1, c, b, r, d);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (count1 !== 16'h0 || busy1 !== 1'b0 || done1 !== 1'b0 || count4 !== 16'h0) begin
      errors++;
      $display("FAIL reset_init: got count1=%h busy1=%b done1=%b count4=%h, expected 0", count1, busy1, done1, count4);
    end
    rst = 0;
    step();
    load = 1; load_val = 16'h0010; step();
    load = 0; start = 1; step();
    start = 0;
    repeat (5) step();
    chk1("reset_prerun", 16'h000B, 1, 1, 0);
    rst = 1;
    #1;
    chk1("reset_async", 16'h0000, 0, 0, 0);
    #2 rst = 0;
    step();
    chk1("reset_idle_stays", 16'h0000, 0, 0, 0);
    start = 1; step();
    start = 0;
    chk1("reset_start_zero_done", 16'h0000, 0, 0, 1);
    step();
    chk1("reset_done_clears", 16'h0000, 0, 0, 0);
  endtask

  task automatic test_prescale1();
    load = 1; load_val = 16'd3; step();
    load = 0; start = 1; step();
    start = 0;
    chk1("ps1_edge0", 16'd3, 1, 1, 0);
    step(); chk1("ps1_edge1", 16'd2, 1, 1, 0);
    step(); chk1("ps1_edge2", 16'd1, 1, 1, 0);
    step(); chk1("ps1_edge3", 16'd0, 0, 0, 1);
    step(); chk1("ps1_after", 16'd0, 0, 0, 0);
  endtask

  task automatic test_prescale4();
    logic [15:0] exp_c;
    logic exp_d;
    load = 1; load_val = 16'd2; step();
    load = 0; start = 1; step();
    start = 0;
    for (int e = 1; e <= 9; e++) begin
      step();
      exp_c = (e < 4) ? 16'd2 : (e < 8) ? 16'd1 : 16'd0;
      exp_d = e == 8;
      checks++;
      if (count4 !== exp_c || done4 !== exp_d || busy4 !== (e < 8)) begin
        errors++;
        $display("FAIL ps4_edge%0d: got count=%h done=%b busy=%b, expected count=%h done=%b busy=%b",
                 e, count4, done4, busy4, exp_c, exp_d, e < 8);
      end
    end
  endtask

  task automatic test_pause_resume();
    load = 1; load_val = 16'h0100; step();
    load = 0; start = 1; step();
    start = 0;
    repeat (10) step();
    chk1("pause_before", 16'h00F6, 1, 1, 0);
    stop = 1;
    repeat (20) step();
    stop = 0;
    chk1("pause_hold", 16'h00F6, 1, 0, 0);
    start = 1; step();
    start = 0;
    chk1("pause_resume", 16'h00F6, 1, 1, 0);
    step(); chk1("pause_resume_dec", 16'h00F5, 1, 1, 0);
  endtask

  task automatic test_auto_reload();
    auto_reload = 1;
    load = 1; load_val = 16'd2; step();
    load = 0; start = 1; step();
    start = 0;
    step(); chk1("ar_1a", 16'd1, 1, 1, 0);
    step(); chk1("ar_reload_a", 16'd2, 1, 1, 1);
    step(); chk1("ar_1b", 16'd1, 1, 1, 0);
    step(); chk1("ar_reload_b", 16'd2, 1, 1, 1);
    auto_reload = 0;
    step(); chk1("ar_off_1", 16'd1, 1, 1, 0);
    step(); chk1("ar_off_done", 16'd0, 0, 0, 1);
    start = 1; step();
    start = 0;
    chk1("done_restart", 16'd2, 1, 1, 0);
  endtask

  task automatic test_collisions();
    load = 1; start = 1; load_val = 16'h1234; step();
    load = 0;
    chk1("col_load_start", 16'h1234, 0, 0, 0);
    step();
    chk1("col_start_run", 16'h1234, 1, 1, 0);
    stop = 1; step();
    stop = 0;
    chk1("col_start_stop_hold", 16'h1234, 1, 0, 0);
    step();
    chk1("col_resume", 16'h1234, 1, 1, 0);
    start = 0; step();
    chk1("col_dec", 16'h1233, 1, 1, 0);
    load = 1; load_val = 16'h0001; step();
    load = 0;
    chk1("col_load_in_run", 16'h0001, 0, 0, 0);
    step();
    chk1("col_idle_holds", 16'h0001, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_prescale1();
    test_prescale4();
    test_pause_resume();
    test_auto_reload();
    test_collisions();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
